// File: rtl/udp_framer.sv
// Wraps a 32-bit payload stream into an Ethernet/IPv4/UDP frame with a fixed
// 42-byte header, so every payload word straddles two output words.
module udp_framer #(
  parameter logic [47:0] SRC_MAC  = 48'h02_00_00_00_00_01,
  parameter logic [47:0] DST_MAC  = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [31:0] SRC_IP   = 32'hC0A8_0001,
  parameter logic [31:0] DST_IP   = 32'hC0A8_0002,
  parameter logic [15:0] SRC_PORT = 16'h04D2,
  parameter logic [15:0] DST_PORT = 16'h04D2,
  parameter logic [7:0]  TTL      = 8'h40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] meta_len,
  input  logic        meta_valid,
  output logic        meta_ready,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic        len_err,
  output logic [2:0]  fsm_state
);

  // Every channel transfers on a rising edge where valid && ready; a source
  // never withdraws or alters valid data until that transfer happens.

  typedef enum logic [2:0] {
    S_IDLE, S_CSUM, S_HDR, S_PAY, S_PAD, S_TAIL, S_DISCARD
  } state_t;

  state_t state, state_nx;

  logic [15:0]  len_q, id_q, ip_id, csum_q, resid;
  logic [8:0]   n_q, pay_cnt;
  logic [3:0]   hdr_idx;
  logic         disc_q;
  logic [319:0] hdr_vec;
  logic [15:0]  ip_len, udp_len;
  logic [19:0]  csum_sum;
  logic [16:0]  csum_f1;
  logic [15:0]  csum_f2, csum_calc;
  logic         load_en, meta_fire, s_fire, len_ok, pay_last, err_now;
  logic         emit, emit_last;
  logic [31:0]  emit_word;
  logic [3:0]   emit_keep;

  function automatic logic [15:0] be16(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  function automatic logic [31:0] be32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  assign load_en   = !m_axis_tvalid || m_axis_tready;
  assign meta_fire = meta_valid && meta_ready;
  assign s_fire    = s_axis_tvalid && s_axis_tready;
  assign len_ok    = (meta_len[1:0] == 2'b00) && (meta_len >= 16'd4) && (meta_len <= 16'd1472);
  assign pay_last  = (pay_cnt == n_q - 9'd1);
  assign err_now   = (state == S_IDLE && meta_fire && !len_ok) ||
                     (state == S_PAY && s_fire && (s_axis_tlast != pay_last));
  assign fsm_state = state;

  assign ip_len  = len_q + 16'd28;
  assign udp_len = len_q + 16'd8;

  // Header checksum over the ten IPv4 header halfwords, checksum field as zero.
  assign csum_sum  = 20'h04500 + 20'(ip_len) + 20'(id_q) + 20'h04000 + 20'({TTL, 8'h11}) +
                     20'(SRC_IP[31:16]) + 20'(SRC_IP[15:0]) +
                     20'(DST_IP[31:16]) + 20'(DST_IP[15:0]);
  assign csum_f1   = 17'(csum_sum[15:0]) + 17'(csum_sum[19:16]);
  assign csum_f2   = csum_f1[15:0] + 16'(csum_f1[16]);
  assign csum_calc = ~csum_f2;

  // Header bytes 0..39, frame byte n at bits [8n+7:8n]; bytes 40-41 come from resid.
  always_comb begin
    hdr_vec = '0;
    for (int i = 0; i < 6; i++) begin
      hdr_vec[8*i +: 8]     = DST_MAC[8*(5-i) +: 8];
      hdr_vec[8*(i+6) +: 8] = SRC_MAC[8*(5-i) +: 8];
    end
    hdr_vec[8*12 +: 16] = be16(16'h0800);
    hdr_vec[8*14 +: 16] = be16(16'h4500);
    hdr_vec[8*16 +: 16] = be16(ip_len);
    hdr_vec[8*18 +: 16] = be16(id_q);
    hdr_vec[8*20 +: 16] = be16(16'h4000);
    hdr_vec[8*22 +: 16] = be16({TTL, 8'h11});
    hdr_vec[8*24 +: 16] = be16(csum_q);
    hdr_vec[8*26 +: 32] = be32(SRC_IP);
    hdr_vec[8*30 +: 32] = be32(DST_IP);
    hdr_vec[8*34 +: 16] = be16(SRC_PORT);
    hdr_vec[8*36 +: 16] = be16(DST_PORT);
    hdr_vec[8*38 +: 16] = be16(udp_len);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (meta_fire) state_nx = len_ok ? S_CSUM : S_DISCARD;
      S_CSUM:    if (load_en) state_nx = S_HDR;
      S_HDR:     if (load_en && hdr_idx == 4'd9) state_nx = S_PAY;
      S_PAY: begin
        if (s_fire) begin
          if (pay_last)          state_nx = S_TAIL;
          else if (s_axis_tlast) state_nx = S_PAD;
        end
      end
      S_PAD:     if (load_en && pay_last) state_nx = S_TAIL;
      S_TAIL:    if (load_en) state_nx = disc_q ? S_DISCARD : S_IDLE;
      S_DISCARD: if (s_axis_tvalid && s_axis_tlast) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    meta_ready    = 1'b0;
    s_axis_tready = 1'b0;
    emit          = 1'b0;
    emit_word     = '0;
    emit_keep     = 4'hF;
    emit_last     = 1'b0;
    if (!rst) begin
      meta_ready    = (state == S_IDLE);
      s_axis_tready = (state == S_PAY && load_en) || (state == S_DISCARD);
    end
    case (state)
      S_CSUM, S_HDR: begin
        emit      = load_en;
        emit_word = hdr_vec[32*hdr_idx +: 32];
      end
      S_PAY: begin
        emit      = s_fire;
        emit_word = {s_axis_tdata[15:0], resid};
      end
      S_PAD: begin
        emit      = load_en;
        emit_word = {16'h0000, resid};
      end
      S_TAIL: begin
        emit      = load_en;
        emit_word = {16'h0000, resid};
        emit_keep = 4'b0011;
        emit_last = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      len_err       <= 1'b0;
      ip_id         <= '0;
      id_q          <= '0;
      len_q         <= '0;
      n_q           <= '0;
      csum_q        <= '0;
      resid         <= '0;
      hdr_idx       <= '0;
      pay_cnt       <= '0;
      disc_q        <= 1'b0;
    end else begin
      len_err <= err_now;
      if (meta_fire && len_ok) begin
        len_q   <= meta_len;
        n_q     <= meta_len[10:2];
        id_q    <= ip_id;
        ip_id   <= ip_id + 16'd1;
        hdr_idx <= '0;
        pay_cnt <= '0;
        resid   <= '0;
        disc_q  <= 1'b0;
      end
      if (state == S_CSUM) csum_q <= csum_calc;
      if (emit) begin
        m_axis_tdata  <= emit_word;
        m_axis_tkeep  <= emit_keep;
        m_axis_tlast  <= emit_last;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (emit && (state == S_CSUM || state == S_HDR)) hdr_idx <= hdr_idx + 4'd1;
      if (state == S_PAY && s_fire) begin
        resid   <= s_axis_tdata[31:16];
        pay_cnt <= pay_cnt + 9'd1;
        if (pay_last && !s_axis_tlast) disc_q <= 1'b1;
      end
      if (state == S_PAD && emit) begin
        resid   <= '0;
        pay_cnt <= pay_cnt + 9'd1;
      end
    end
  end

endmodule

// File: tb/tb_udp_framer.sv
// Bench for udp_framer: a byte-level frame model feeds an expected-word queue
// that a single negedge monitor checks against every accepted output word.
module tb_udp_framer;

  localparam logic [47:0] P_SRC_MAC  = 48'h02_00_00_00_00_01;
  localparam logic [47:0] P_DST_MAC  = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [31:0] P_SRC_IP   = 32'hC0A8_0001;
  localparam logic [31:0] P_DST_IP   = 32'hC0A8_0002;
  localparam logic [15:0] P_SRC_PORT = 16'h04D2;
  localparam logic [15:0] P_DST_PORT = 16'h04D2;
  localparam logic [7:0]  P_TTL      = 8'h40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] meta_len = '0;
  logic        meta_valid = 1'b0;
  logic        meta_ready;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b1;
  logic        len_err;
  logic [2:0]  fsm_state;

  udp_framer dut (
    .clk(clk), .rst(rst),
    .meta_len(meta_len), .meta_valid(meta_valid), .meta_ready(meta_ready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .len_err(len_err), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          err_cnt = 0;
  int          words_seen = 0;
  logic [36:0] exp_q[$];
  logic [31:0] cap[$];
  logic [7:0]  mb[$];
  logic [31:0] mpay[$];
  logic [15:0] next_id = '0;
  logic        stall_en = 1'b0;
  logic        rst_seen = 1'b0;
  logic        held_valid = 1'b0;
  logic [36:0] held_word = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function void p8(input logic [7:0] v);
    mb.push_back(v);
  endfunction

  function void p16(input logic [15:0] v);
    mb.push_back(v[15:8]);
    mb.push_back(v[7:0]);
  endfunction

  // Lays the whole frame out as bytes, then slices it into little-lane words.
  function void model_frame(input int len);
    logic [16:0] s;
    logic [15:0] cs;
    int nw;
    mb.delete();
    for (int i = 5; i >= 0; i--) p8(P_DST_MAC[8*i +: 8]);
    for (int i = 5; i >= 0; i--) p8(P_SRC_MAC[8*i +: 8]);
    p16(16'h0800); p8(8'h45); p8(8'h00); p16(16'(28 + len)); p16(next_id);
    p16(16'h4000); p8(P_TTL); p8(8'h11); p16(16'h0000);
    for (int i = 3; i >= 0; i--) p8(P_SRC_IP[8*i +: 8]);
    for (int i = 3; i >= 0; i--) p8(P_DST_IP[8*i +: 8]);
    p16(P_SRC_PORT); p16(P_DST_PORT); p16(16'(8 + len)); p16(16'h0000);
    s = '0;
    for (int i = 14; i < 34; i += 2) begin
      s = s + {1'b0, mb[i], mb[i+1]};
      if (s[16]) s = {1'b0, s[15:0]} + 17'd1;
    end
    cs = ~s[15:0];
    mb[24] = cs[15:8];
    mb[25] = cs[7:0];
    for (int j = 0; j < len / 4; j++)
      for (int i = 0; i < 4; i++) p8(mpay[j][8*i +: 8]);
    p8(8'h00); p8(8'h00);
    nw = mb.size() / 4;
    for (int w = 0; w < nw; w++)
      exp_q.push_back({(w == nw - 1), ((w == nw - 1) ? 4'b0011 : 4'hF),
                       mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]});
    next_id = next_id + 16'd1;
  endfunction

  always @(posedge clk) rst_seen <= rst;

  initial begin
    forever begin
      @(posedge clk); #1;
      m_axis_tready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_seen) begin
      chk("reset tvalid", m_axis_tvalid, 0);
      chk("reset tdata", m_axis_tdata, 0);
      chk("reset tkeep", m_axis_tkeep, 0);
      chk("reset tlast", m_axis_tlast, 0);
      chk("reset len_err", len_err, 0);
      held_valid = 1'b0;
    end else begin
      if (len_err) err_cnt++;
      if (held_valid)
        chk("stall hold", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, {1'b1, held_word});
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected word: got %0h, expected none (t=%0t)", m_axis_tdata, $time);
        end else begin
          chk("frame word", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, exp_q.pop_front());
        end
        cap.push_back(m_axis_tdata);
        words_seen++;
      end
      held_valid = m_axis_tvalid && !m_axis_tready;
      held_word  = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
    end
    if (rst) begin
      chk("reset meta_ready", meta_ready, 0);
      chk("reset s_tready", s_axis_tready, 0);
      exp_q.delete();
      held_valid = 1'b0;
    end
  end

  task automatic send_meta(input logic [15:0] len);
    logic ok = 1'b0;
    meta_len   = len;
    meta_valid = 1'b1;
    for (int b = 0; b < 2000 && !ok; b++) begin
      @(negedge clk); ok = meta_ready;
      @(posedge clk); #1;
    end
    meta_valid = 1'b0;
    if (!ok) chk("meta handshake timeout", 0, 1);
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    logic ok = 1'b0;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    for (int b = 0; b < 2000 && !ok; b++) begin
      @(negedge clk); ok = s_axis_tready;
      @(posedge clk); #1;
    end
    if (!ok) chk("payload handshake timeout", 0, 1);
  endtask

  task automatic wait_drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 5000) begin
      @(posedge clk); #1;
      b++;
    end
    chk("drain words left", exp_q.size(), 0);
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    next_id = '0;
  endtask

  function automatic logic [31:0] pat(input logic [31:0] base, input int j);
    return base + 32'(j) * 32'h0102_0408;
  endfunction

  task automatic do_frame(input int len, input int n_send, input int last_idx, input logic [31:0] base);
    mpay.delete();
    for (int j = 0; j < len / 4; j++)
      mpay.push_back((j < n_send && j <= last_idx) ? pat(base, j) : 32'h0);
    if (len % 4 == 0 && len >= 4 && len <= 1472) model_frame(len);
    send_meta(16'(len));
    for (int j = 0; j < n_send; j++) send_word(pat(base, j), (j == last_idx));
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    wait_drain();
  endtask

  initial begin
    int e0, w0, b;
    logic [31:0] t;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;

    // L=8 reference frame with hand-computed words
    cap.delete();
    mpay = '{32'h4433_2211, 32'h8877_6655};
    model_frame(8);
    send_meta(16'd8);
    @(negedge clk); chk("latency csum cycle tvalid", m_axis_tvalid, 0);
    @(negedge clk); chk("latency first word tvalid", m_axis_tvalid, 1);
    chk("word0 dst mac", m_axis_tdata, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    send_word(32'h4433_2211, 1'b0);
    send_word(32'h8877_6655, 1'b1);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    wait_drain();
    chk("l8 word count", cap.size(), 13);
    chk("l8 word1", cap[1], 32'h0002_FFFF);
    chk("l8 word4 ip len", cap[4], 32'h0000_2400);
    chk("l8 word6 csum", cap[6], 32'hA8C0_75B9);
    chk("l8 word9 udp len", cap[9], 32'h1000_D204);
    chk("l8 word10", cap[10], 32'h2211_0000);
    chk("l8 word11", cap[11], 32'h6655_4433);
    chk("l8 word12", cap[12], 32'h0000_8877);

    // back-to-back minimum frames after reset: IP ID 0 then 1
    do_reset();
    cap.delete();
    mpay = '{32'hA1A2_A3A4}; model_frame(4);
    send_meta(16'd4); send_word(32'hA1A2_A3A4, 1'b1);
    mpay = '{32'h5A5A_0F0F}; model_frame(4);
    send_meta(16'd4); send_word(32'h5A5A_0F0F, 1'b1);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    wait_drain();
    chk("b2b word count", cap.size(), 24);
    t = cap[4];  chk("b2b first ip id", t[31:16], 16'h0000);
    t = cap[16]; chk("b2b second ip id", t[31:16], 16'h0100);

    // downstream stalls during a 64-byte frame
    stall_en = 1'b1;
    do_frame(64, 16, 15, 32'h8000_1111);
    stall_en = 1'b0;

    // bad length 6: dropped, one error pulse, ID untouched
    e0 = err_cnt; cap.delete();
    do_frame(6, 3, 2, 32'h0BAD_0000);
    chk("len6 err pulses", err_cnt - e0, 1);
    chk("len6 no output", cap.size(), 0);
    do_frame(4, 1, 0, 32'h1234_5678);

    // early tlast: padding words
    e0 = err_cnt; cap.delete();
    do_frame(16, 2, 1, 32'hCAFE_0001);
    chk("early tlast err", err_cnt - e0, 1);
    chk("early tlast word count", cap.size(), 15);
    t = cap[12]; chk("early tlast pad upper", t[31:16], 16'h0000);
    chk("early tlast word13", cap[13], 32'h0000_0000);

    // missing tlast: frame completes, rest of packet discarded
    e0 = err_cnt; cap.delete();
    do_frame(8, 4, 3, 32'hBEEF_0010);
    chk("missing tlast err", err_cnt - e0, 1);
    chk("missing tlast word count", cap.size(), 13);
    do_frame(4, 1, 0, 32'h0F0E_0D0C);

    // length boundaries
    e0 = err_cnt; cap.delete();
    do_frame(0, 1, 0, 32'h0);
    do_frame(1476, 2, 1, 32'h7777_0000);
    do_frame(5, 1, 0, 32'h0);
    chk("bad lengths err", err_cnt - e0, 3);
    chk("bad lengths no output", cap.size(), 0);
    cap.delete();
    do_frame(1472, 368, 367, 32'h0001_0203);
    chk("max len word count", cap.size(), 379);

    // reset while word 5 is on the output
    mpay = '{32'h1, 32'h2, 32'h3, 32'h4};
    model_frame(16);
    w0 = words_seen;
    send_meta(16'd16);
    b = 0;
    while (words_seen - w0 != 5 && b < 200) begin
      @(posedge clk); #1; b++;
    end
    chk("reach word 5", words_seen - w0, 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    next_id = '0;
    cap.delete();
    repeat (30) begin @(posedge clk); #1; end
    chk("no words after reset", cap.size(), 0);
    do_frame(4, 1, 0, 32'h4242_4242);
    t = cap[4]; chk("ip id after reset", t[31:16], 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
